inst_queue: RTL and testbench
=============================

# inst_queue

Decoupling FIFO between the fetch/I-cache stage and the decoder of the out-of-order MIPS core. Fetch pushes one instruction per cycle tagged with its PC; the decoder pops one per cycle when decode is not stalled. The block exports `full` and `almost_full` to the hazard controller, which uses `full` to stall fetch. A control-flow redirect flushes the whole queue in one cycle.

## Interface
Parameters:
- DEPTH, 8: number of entries; power of two, minimum 2.
- AF_THRESH, DEPTH-2: occupancy at or above which `almost_full` asserts.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  fetch presents a valid instruction this cycle.
- in_pc  in  ADDR_WIDTH  PC of the presented instruction.
- in_instr  in  DATA_WIDTH  instruction word.
- pop  in  1  decoder consumes the head this cycle (driven as !decode-stall).
- flush  in  1  discard all entries (decode flush / fetch redirect).
- out_valid  out  1  head entry is valid.
- out_pc  out  ADDR_WIDTH  head PC.
- out_instr  out  DATA_WIDTH  head instruction.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: DEPTH-entry circular buffer; write pointer `wr_ptr` and read pointer `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH; separate occupancy counter `count`.
- push_acc = in_valid & !full & !flush. `full` is the registered-state value; a push is rejected when full even if `pop` is asserted that cycle (no combinational pop-to-push path).
- pop_acc = pop & out_valid & !flush.
- On push_acc: entry[wr_ptr] <= {in_pc, in_instr}; wr_ptr <= wr_ptr+1.
- On pop_acc: rd_ptr <= rd_ptr+1.
- count next = count + push_acc - pop_acc; simultaneous push and pop leaves count unchanged.
- flush: rd_ptr, wr_ptr, count <= 0 next cycle; any push or pop in the same cycle is ignored.
- Pop while empty: ignored, no state change. Push while full: dropped; fetch is required to hold the instruction (it is stalled by `full`).
- Outputs out_pc/out_instr are entry[rd_ptr] (combinational read of the register array); out_valid = (count != 0).

## Timing
- Reset (rst_n low at clk edge): pointers and count 0; out_valid 0, full 0, almost_full 0 (AF_THRESH>0), count 0. Storage contents are not reset; out_pc/out_instr are don't-care while out_valid = 0.
- Push-to-visible latency: 1 cycle (entry pushed in cycle N is at head in cycle N+1 if queue was empty).
- full/almost_full/count reflect state after the previous edge; asserted within 1 cycle of the push that fills.
- Flush in cycle N: out_valid = 0 in N+1; a push in N+1 becomes visible in N+2.
- Reset mid-operation overrides push, pop and flush.

## Configuration
- INST_Q_BYPASS_EN defined: when count == 0, in_valid = 1 and flush = 0, the incoming instruction drives out_valid/out_pc/out_instr combinationally in the same cycle; if pop is also asserted it is consumed directly and not written (count stays 0, pointers unchanged); if pop is low it is written as normal.
- Not defined: strictly registered behaviour above; out_valid depends only on count.

## Structure
- ADDR_WIDTH, DATA_WIDTH from the shared mips_core package; typedef `inst_q_entry_t` (struct {pc, instr}) added to the same package for reuse by fetch and decode.
- Single module, no sub-module; storage is an inline array of `inst_q_entry_t`.

## Test plan
- Reset, then push PCs 0x100,0x104,0x108 with pop=0 -> count=3, out_pc=0x100; pop 3 cycles -> heads 0x100,0x104,0x108 then out_valid=0.
- Push 8 entries (DEPTH=8), pop=0 -> almost_full at count=6, full at 8; 9th push (0x200) with pop=1 -> rejected, count=7, 0x200 never appears.
- Steady push+pop every cycle with count=4 for 20 cycles -> count stays 4, output order matches input order across pointer wrap.
- Count=5, assert flush with in_valid=1 and pop=1 -> next cycle count=0, out_valid=0, pushed entry discarded.
- Empty queue, in_valid=1 pc=0x300, pop=1 -> without macro: out_valid=0 that cycle, 0x300 at head next cycle; with INST_Q_BYPASS_EN: out_valid=1 out_pc=0x300 same cycle, count remains 0.
- Assert rst_n low with count=6 -> next cycle count=0, full=0, almost_full=0, out_valid=0.

Source files
------------

// File: rtl/mips_core_pkg.sv
// ---------------------------------------------------------------------------
// mips_core_pkg
//   Shared definitions for the out-of-order MIPS core.
//   ADDR_WIDTH / DATA_WIDTH : PC and instruction-word widths.
//   inst_q_entry_t          : one instruction-queue entry {pc, instr}.
//                             Fetch, the queue and decode all use this type.
// ---------------------------------------------------------------------------
package mips_core_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } inst_q_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// ---------------------------------------------------------------------------
// inst_queue_if
//   Handshake bundle between fetch/decode (master) and inst_queue (slave).
//   master drives : in_valid, in_pc, in_instr, pop, flush
//   master sees   : out_valid, out_pc, out_instr, full, almost_full, count
//   DEPTH must match the DEPTH of the attached inst_queue (sets count width).
// ---------------------------------------------------------------------------
interface inst_queue_if
    import mips_core_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic [DATA_WIDTH-1:0] in_instr;
    logic                  pop;
    logic                  flush;
    logic                  out_valid;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [DATA_WIDTH-1:0] out_instr;
    logic                  full;
    logic                  almost_full;
    logic [CW-1:0]         count;

    modport master (
        output in_valid, in_pc, in_instr, pop, flush,
        input  out_valid, out_pc, out_instr, full, almost_full, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, pop, flush,
        output out_valid, out_pc, out_instr, full, almost_full, count
    );

endinterface

// File: rtl/inst_queue.sv
// ---------------------------------------------------------------------------
// inst_queue
//   Decoupling FIFO between fetch/I-cache and the decoder. One push and one
//   pop per cycle, single-cycle flush on redirect.
//
//   Parameters : DEPTH (power of two, >= 2), AF_THRESH (almost_full level)
//   Ports      : clk, rst_n (synchronous, active-low)
//                q (inst_queue_if.slave) - push/pop/flush in, head entry and
//                occupancy flags out.
//
//   Optional feature macro: INST_Q_BYPASS_EN
//     Defined   : an instruction arriving at an empty queue is presented on
//                 the head outputs in the same cycle; if popped in that cycle
//                 it is consumed directly and never written.
//     Undefined : head outputs come only from the registered storage.
// ---------------------------------------------------------------------------
module inst_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic         clk,
    input  logic         rst_n,
    inst_queue_if.slave  q
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    inst_q_entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_r;

    logic          full_r;
    logic          empty;
    logic          stored_valid;
    logic          push_acc;
    logic          pop_acc;
    logic          bypass_take;

    // Flags come from registered state only, so pop can never free a slot
    // for a push in the same cycle.
    assign full_r       = (count_r == CW'(DEPTH));
    assign empty        = (count_r == '0);
    assign stored_valid = !empty;

`ifdef INST_Q_BYPASS_EN
    logic bypass_hit;

    // Empty queue with a live incoming instruction: show it straight away.
    assign bypass_hit  = empty && q.in_valid && !q.flush;
    assign bypass_take = bypass_hit && q.pop;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        q.out_valid = stored_valid;
        q.out_pc    = mem[rd_ptr].pc;
        q.out_instr = mem[rd_ptr].instr;
        if (bypass_hit) begin
            q.out_valid = 1'b1;
            q.out_pc    = q.in_pc;
            q.out_instr = q.in_instr;
        end
    end
`else
    assign bypass_take = 1'b0;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        q.out_valid = stored_valid;
        q.out_pc    = mem[rd_ptr].pc;
        q.out_instr = mem[rd_ptr].instr;
    end
`endif

    // A bypassed-and-consumed instruction touches neither storage nor count.
    // pop_acc uses stored_valid so a bypassed head cannot move rd_ptr.
    assign push_acc = q.in_valid && !full_r && !q.flush && !bypass_take;
    assign pop_acc  = q.pop && stored_valid && !q.flush;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else if (q.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            count_r <= count_r + CW'(push_acc) - CW'(pop_acc);
        end
    end

    // NOTE: storage is deliberately left out of reset; entries are only
    // observable through out_valid, which is derived from the reset count.
    always_ff @(posedge clk) begin
        if (rst_n && push_acc) begin
            mem[wr_ptr] <= '{pc: q.in_pc, instr: q.in_instr};
        end
    end

    assign q.full        = full_r;
    assign q.almost_full = (count_r >= CW'(AF_THRESH));
    assign q.count       = count_r;

endmodule

// File: tb/tb_inst_queue.sv
// ---------------------------------------------------------------------------
// tb_inst_queue
//   Directed self-checking bench for inst_queue (DEPTH = 8, AF_THRESH = 6).
//   Inputs change 1 time unit after the rising edge; outputs are sampled
//   1-2 time units after the edge, well away from it.
// ---------------------------------------------------------------------------
module tb_inst_queue;
    import mips_core_pkg::*;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    inst_queue_if #(.DEPTH(DEPTH)) qi ();

    inst_queue #(
        .DEPTH     (DEPTH),
        .AF_THRESH (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (qi.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return pc ^ 32'h2400_0000;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic p, input logic f);
        qi.in_valid = v;
        qi.in_pc    = pc;
        qi.in_instr = iw(pc);
        qi.pop      = p;
        qi.flush    = f;
    endtask

    logic [31:0] expq [$];
    logic [31:0] pc;

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_count", 32'(qi.count), 32'd0);
        check("rst_valid", 32'(qi.out_valid), 32'd0);
        check("rst_full", 32'(qi.full), 32'd0);
        check("rst_af", 32'(qi.almost_full), 32'd0);

        // Three pushes then three pops.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t1_count", 32'(qi.count), 32'd3);
        check("t1_valid", 32'(qi.out_valid), 32'd1);
        check("t1_head", qi.out_pc, 32'h100);
        check("t1_instr", qi.out_instr, iw(32'h100));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            check("t1_pop_head", qi.out_pc, 32'h100 + 32'(4 * i));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t1_empty_valid", 32'(qi.out_valid), 32'd0);
        check("t1_empty_count", 32'(qi.count), 32'd0);

        // Fill to DEPTH, watch the flags, then try a push while full.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
            tick();
            check("t2_af", 32'(qi.almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
            check("t2_full", 32'(qi.full), (i + 1 == 8) ? 32'd1 : 32'd0);
        end
        check("t2_count8", 32'(qi.count), 32'd8);
        drive(1'b1, 32'h200, 1'b1, 1'b0);
        tick();
        check("t2_count7", 32'(qi.count), 32'd7);
        check("t2_full_clr", 32'(qi.full), 32'd0);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            #1;
            check("t2_drain_head", qi.out_pc, 32'h400 + 32'(4 * i));
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t2_drained", 32'(qi.out_valid), 32'd0);

        // Steady state: four entries, push+pop every cycle across the wrap.
        for (int i = 0; i < 4; i++) begin
            pc = 32'h500 + 32'(4 * i);
            drive(1'b1, pc, 1'b0, 1'b0);
            expq.push_back(pc);
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            pc = 32'h600 + 32'(4 * k);
            drive(1'b1, pc, 1'b1, 1'b0);
            #1;
            check("t3_head", qi.out_pc, expq[0]);
            check("t3_instr", qi.out_instr, iw(expq[0]));
            void'(expq.pop_front());
            expq.push_back(pc);
            tick();
            check("t3_count", 32'(qi.count), 32'd4);
        end

        // Reach five entries, then flush with a push and pop in the same cycle.
        drive(1'b1, 32'h6f0, 1'b0, 1'b0);
        tick();
        check("t4_count5", 32'(qi.count), 32'd5);
        drive(1'b1, 32'h6f4, 1'b1, 1'b1);
        tick();
        drive(1'b1, 32'h700, 1'b0, 1'b0);
        #1;
        check("t4_flush_count", 32'(qi.count), 32'd0);
        check("t4_flush_valid", 32'(qi.out_valid), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t4_post_count", 32'(qi.count), 32'd1);
        check("t4_post_head", qi.out_pc, 32'h700);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t4_clean", 32'(qi.count), 32'd0);

        // Push into an empty queue with pop asserted.
        drive(1'b1, 32'h300, 1'b1, 1'b0);
        #1;
`ifdef INST_Q_BYPASS_EN
        check("t5_byp_valid", 32'(qi.out_valid), 32'd1);
        check("t5_byp_pc", qi.out_pc, 32'h300);
        check("t5_byp_instr", qi.out_instr, iw(32'h300));
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t5_byp_count", 32'(qi.count), 32'd0);
        check("t5_byp_after", 32'(qi.out_valid), 32'd0);
`else
        check("t5_reg_valid", 32'(qi.out_valid), 32'd0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t5_reg_next_valid", 32'(qi.out_valid), 32'd1);
        check("t5_reg_next_pc", qi.out_pc, 32'h300);
        check("t5_reg_count", 32'(qi.count), 32'd1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
`endif

        // Reset in the middle of traffic.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 32'h800 + 32'(4 * i), 1'b0, 1'b0);
            tick();
        end
        check("t6_count6", 32'(qi.count), 32'd6);
        check("t6_af", 32'(qi.almost_full), 32'd1);
        drive(1'b1, 32'h900, 1'b1, 1'b1);
        rst_n = 1'b0;
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        check("t6_rst_count", 32'(qi.count), 32'd0);
        check("t6_rst_full", 32'(qi.full), 32'd0);
        check("t6_rst_af", 32'(qi.almost_full), 32'd0);
        check("t6_rst_valid", 32'(qi.out_valid), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
